mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_arbiter: shares one single-port memory between fetch and load/store,     |
// | routing each response back to its owner MEM_LATENCY (1-4) cycles later.     |
// | Option: ARB_ROUND_ROBIN_EN (undefined = fixed priority, data over fetch).    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic [DATA_WIDTH/8-1:0] d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam logic [0:0] c_own_fetch = 1'b0;
  localparam logic [0:0] c_own_data  = 1'b1;
  localparam int         c_head      = MEM_LATENCY - 1;

  logic w_if_act;
  logic w_d_act;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_gnt;
  logic w_head_vld;

  logic [MEM_LATENCY-1:0] r_vld;
  logic [MEM_LATENCY-1:0] r_own;

  // A flushing fetch port can never win, which also lets data through that cycle.
  assign w_if_act = if_req & ~if_flush & ~reset;
  assign w_d_act  = d_req & ~reset;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_data <= c_own_fetch;
    end else if (w_gnt) begin
      r_last_data <= w_d_gnt;
    end
  end

  assign w_d_gnt = w_d_act & (~w_if_act | (r_last_data == c_own_fetch));
`else
  assign w_d_gnt = w_d_act;
`endif

  assign w_if_gnt = w_if_act & ~w_d_gnt;
  assign w_gnt    = w_if_gnt | w_d_gnt;

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_en    = w_gnt;
  assign mem_we    = w_d_gnt ? d_we : '0;
  assign mem_addr  = w_d_gnt ? d_addr : if_addr;
  assign mem_wdata = w_d_gnt ? d_wdata : '0;

  // Stage 0 is loaded by the grant; a flush kills fetch entries as they advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= w_gnt;
      r_own[0] <= w_d_gnt;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1] & ~(if_flush & (r_own[i-1] == c_own_fetch));
        r_own[i] <= r_own[i-1];
      end
    end
  end

  // The head entry is masked directly so a same-cycle flush also drops it.
  assign w_head_vld = r_vld[c_head] & ~reset;
  assign if_rvalid  = w_head_vld & (r_own[c_head] == c_own_fetch) & ~if_flush;
  assign d_rvalid   = w_head_vld & (r_own[c_head] == c_own_data);
  assign if_rdata   = mem_rdata;
  assign d_rdata    = mem_rdata;

endmodule
`default_nettype wire
